hawk_cmpdcmp_axi_wr_issue: RTL and testbench

AXI4 write-issue stage directly downstream of the HAWK compress/decompress write manager. Takes the manager's single-beat write requests, which arrive as independent address and data valid/ready pulses, and registers them into one-entry AW and W skid buffers. It issues them on the AXI4 master write channels, caps outstanding transactions, retires B responses and provides a drain handshake so the manager can confirm that all page writes have landed before it reports completion.

---
 rtl/hawk_cmpdcmp_axi_wr_issue.sv | 278 +++++++++++++++++++++++++++
 tb/tb_hawk_cmpdcmp_axi_wr_issue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_cmpdcmp_axi_wr_issue.sv
// ---------------------------------------------------------------------------
// hawk_cmpdcmp_axi_wr_issue
//
// AXI4 write-issue stage sitting behind the HAWK compress/decompress write
// manager. Single-beat write requests arrive as independent address and data
// valid/ready pulses. Each one is captured in a one-entry skid buffer (AW and W)
// and issued on the AXI4 master write channels. The stage caps outstanding
// transactions, retires B responses and offers a drain handshake that lets the
// manager confirm that every page write has landed.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_awvalid/req_awready  address request from the write manager
//   req_addr                 line-aligned write address
//   req_wvalid/req_wready    data request from the write manager
//   req_data, req_strb       line data and byte strobes
//   m_aw*                    AXI4 AW channel (single beat, INCR, 64-byte size)
//   m_w*                     AXI4 W channel (wlast always 1)
//   m_b*                     AXI4 B channel (bready held high, bid ignored)
//   drain_req_i              level request to drain all in-flight writes
//   drain_done_o             one-cycle pulse once everything has drained
//   outstd_cnt_o             AW handshakes that are still waiting for a B response
//   err_o, err_clr_i         sticky response error and its clear
//
// Optional feature macro: HAWK_AXI_WR_ISSUE_BRESP_CHK_EN
//   defined   : err_o sets on a B response carrying SLVERR/DECERR, or on a B
//               response that arrives while nothing is outstanding.
//   undefined : err_o is tied low and m_bresp is ignored.
// ---------------------------------------------------------------------------
module hawk_cmpdcmp_axi_wr_issue #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int ID_W       = 4,
  parameter int AXI_ID     = 0,
  parameter int MAX_OUTSTD = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_awvalid,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  req_awready,
  input  logic                  req_wvalid,
  input  logic [DATA_W-1:0]     req_data,
  input  logic [DATA_W/8-1:0]   req_strb,
  output logic                  req_wready,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [ID_W-1:0]       m_awid,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wlast,
  input  logic                  m_bvalid,
  input  logic [1:0]            m_bresp,
  input  logic [ID_W-1:0]       m_bid,
  output logic                  m_bready,
  input  logic                  drain_req_i,
  output logic                  drain_done_o,
  output logic [3:0]            outstd_cnt_o,
  output logic                  err_o,
  input  logic                  err_clr_i
);

  localparam int         STRB_W  = DATA_W / 8;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTD);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              r_st;
  logic                r_aw_full;
  logic [ADDR_W-1:0]   r_awaddr;
  logic                r_w_full;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [3:0]          r_outstd;
  logic [3:0]          r_pend_w;
  logic                r_bready;
  logic                r_done;

  logic                w_run;
  logic                w_below_cap;
  logic                w_awvalid;
  logic                w_wvalid;
  logic                w_aw_fire;
  logic                w_w_fire;
  logic                w_b_fire;
  logic                w_aw_acc;
  logic                w_w_acc;
  logic                w_aw_full_nxt;
  logic                w_w_full_nxt;
  logic [3:0]          w_outstd_nxt;
  logic [3:0]          w_pend_w_nxt;
  logic                w_idle_nxt;
  logic                w_unused;

  // Handshake qualifiers; AW is gated by the outstanding cap, W waits for its AW.
  assign w_run       = (r_st == ST_RUN);
  assign w_below_cap = (r_outstd < MAX_CNT);
  assign w_awvalid   = r_aw_full & w_below_cap;
  assign w_wvalid    = r_w_full & (r_pend_w != 4'd0);
  assign w_aw_fire   = w_awvalid & m_awready;
  assign w_w_fire    = w_wvalid & m_wready;
  assign w_b_fire    = m_bvalid & r_bready;

  // Accepting while issuing in the same cycle reloads the buffer, giving full rate.
  assign req_awready = w_run & (~r_aw_full | w_aw_fire);
  assign req_wready  = w_run & (~r_w_full | w_w_fire);
  assign w_aw_acc    = req_awvalid & req_awready;
  assign w_w_acc     = req_wvalid & req_wready;

  // Next-state values for the skids and counters, shared with the drain lookahead.
  always_comb begin
    w_aw_full_nxt = r_aw_full;
    w_w_full_nxt  = r_w_full;
    w_outstd_nxt  = r_outstd;
    w_pend_w_nxt  = r_pend_w;

    if (w_aw_acc) begin
      w_aw_full_nxt = 1'b1;
    end else if (w_aw_fire) begin
      w_aw_full_nxt = 1'b0;
    end else begin
      w_aw_full_nxt = r_aw_full;
    end

    if (w_w_acc) begin
      w_w_full_nxt = 1'b1;
    end else if (w_w_fire) begin
      w_w_full_nxt = 1'b0;
    end else begin
      w_w_full_nxt = r_w_full;
    end

    // A B response with nothing outstanding leaves the count at zero.
    case ({w_aw_fire, w_b_fire})
      2'b10: w_outstd_nxt = r_outstd + 4'd1;
      2'b01: begin
        if (r_outstd != 4'd0) begin
          w_outstd_nxt = r_outstd - 4'd1;
        end else begin
          w_outstd_nxt = r_outstd;
        end
      end
      default: w_outstd_nxt = r_outstd;
    endcase

    case ({w_aw_fire, w_w_fire})
      2'b10: w_pend_w_nxt = r_pend_w + 4'd1;
      2'b01: begin
        if (r_pend_w != 4'd0) begin
          w_pend_w_nxt = r_pend_w - 4'd1;
        end else begin
          w_pend_w_nxt = r_pend_w;
        end
      end
      default: w_pend_w_nxt = r_pend_w;
    endcase
  end

  // Looking at next-state values lets drain complete the cycle after the last B.
  assign w_idle_nxt = ~w_aw_full_nxt & ~w_w_full_nxt &
                      (w_outstd_nxt == 4'd0) & (w_pend_w_nxt == 4'd0);

  // AW skid buffer: occupancy flag and address payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_full <= 1'b0;
      r_awaddr  <= {ADDR_W{1'b0}};
    end else begin
      r_aw_full <= w_aw_full_nxt;
      if (w_aw_acc) begin
        r_awaddr <= req_addr;
      end
    end
  end

  // W skid buffer: occupancy flag, data and strobe payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_w_full <= 1'b0;
      r_wdata  <= {DATA_W{1'b0}};
      r_wstrb  <= {STRB_W{1'b0}};
    end else begin
      r_w_full <= w_w_full_nxt;
      if (w_w_acc) begin
        r_wdata <= req_data;
        r_wstrb <= req_strb;
      end
    end
  end

  // Outstanding-transaction and pending-W counters; bready is held high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstd <= 4'd0;
      r_pend_w <= 4'd0;
      r_bready <= 1'b1;
    end else begin
      r_outstd <= w_outstd_nxt;
      r_pend_w <= w_pend_w_nxt;
      r_bready <= 1'b1;
    end
  end

  // Drain FSM with its registered completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_st   <= ST_RUN;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_st)
        ST_RUN: begin
          if (drain_req_i) begin
            r_st <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_idle_nxt) begin
            r_st   <= ST_DONE;
            r_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_st <= ST_RUN;
        end
        default: begin
          r_st <= ST_RUN;
        end
      endcase
    end
  end

`ifdef HAWK_AXI_WR_ISSUE_BRESP_CHK_EN
  logic r_err;

  // Sticky response error; a new error wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_b_fire & (m_bresp[1] | (r_outstd == 4'd0))) begin
      r_err <= 1'b1;
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end

  assign err_o    = r_err;
  assign w_unused = ^m_bid;
`else
  assign err_o    = 1'b0;
  assign w_unused = ^{m_bid, m_bresp, err_clr_i};
`endif

  assign m_awvalid    = w_awvalid;
  assign m_awaddr     = r_awaddr;
  assign m_awid       = ID_W'(AXI_ID);
  assign m_awlen      = 8'd0;
  assign m_awsize     = 3'd6;
  assign m_awburst    = 2'b01;
  assign m_wvalid     = w_wvalid;
  assign m_wdata      = r_wdata;
  assign m_wstrb      = r_wstrb;
  assign m_wlast      = 1'b1;
  assign m_bready     = r_bready;
  assign drain_done_o = r_done;
  assign outstd_cnt_o = r_outstd;

endmodule

// File: tb/tb_hawk_cmpdcmp_axi_wr_issue.sv
// Directed testbench for hawk_cmpdcmp_axi_wr_issue (default parameters).
module tb_hawk_cmpdcmp_axi_wr_issue;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int ID_W   = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                req_awvalid;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_awready;
  logic                req_wvalid;
  logic [DATA_W-1:0]   req_data;
  logic [DATA_W/8-1:0] req_strb;
  logic                req_wready;
  logic                m_awvalid;
  logic                m_awready;
  logic [ADDR_W-1:0]   m_awaddr;
  logic [ID_W-1:0]     m_awid;
  logic [7:0]          m_awlen;
  logic [2:0]          m_awsize;
  logic [1:0]          m_awburst;
  logic                m_wvalid;
  logic                m_wready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wlast;
  logic                m_bvalid;
  logic [1:0]          m_bresp;
  logic [ID_W-1:0]     m_bid;
  logic                m_bready;
  logic                drain_req_i;
  logic                drain_done_o;
  logic [3:0]          outstd_cnt_o;
  logic                err_o;
  logic                err_clr_i;

  int n_vec = 0;
  int n_bad = 0;

  // traffic generator state
  int          aw_sent, w_sent, aw_hs, w_hs, b_hs, aw_lim, w_lim;
  logic [63:0] base;
  bit          b_auto, b_force;
  bit          got_aw, got_w;
  logic [63:0] cap_awaddr;
  logic [DATA_W-1:0] cap_wdata;

`ifdef HAWK_AXI_WR_ISSUE_BRESP_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  hawk_cmpdcmp_axi_wr_issue dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_awvalid(req_awvalid), .req_addr(req_addr), .req_awready(req_awready),
    .req_wvalid(req_wvalid), .req_data(req_data), .req_strb(req_strb), .req_wready(req_wready),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready),
    .drain_req_i(drain_req_i), .drain_done_o(drain_done_o), .outstd_cnt_o(outstd_cnt_o),
    .err_o(err_o), .err_clr_i(err_clr_i)
  );

  function automatic logic [DATA_W-1:0] pat(input int k);
    logic [31:0] w;
    w = 32'hC0DE0000 | 32'(k);
    return {16{w}};
  endfunction

  task automatic clear_traffic(input logic [63:0] b);
    aw_sent = 0; w_sent = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    base = b; b_auto = 1'b0; b_force = 1'b0;
  endtask

  // One clock of generated traffic; records handshakes seen in this cycle.
  task automatic run_cycle();
    @(negedge clk_i);
    req_awvalid = (aw_sent < aw_lim);
    req_addr    = base + 64'(64 * aw_sent);
    req_wvalid  = (w_sent < w_lim);
    req_data    = pat(w_sent);
    req_strb    = '1;
    m_bvalid    = b_force | (b_auto & (b_hs < aw_hs));
    m_bresp     = 2'b00;
    #1;
    got_aw     = m_awvalid & m_awready;
    got_w      = m_wvalid & m_wready;
    cap_awaddr = m_awaddr;
    cap_wdata  = m_wdata;
    if (req_awvalid && req_awready) aw_sent++;
    if (req_wvalid && req_wready) w_sent++;
    if (got_aw) aw_hs++;
    if (got_w) w_hs++;
    if (m_bvalid && m_bready) b_hs++;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_awvalid = 1'b0; req_addr = '0; req_wvalid = 1'b0; req_data = '0;
    req_strb = '0; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_bid = '0; drain_req_i = 1'b0; err_clr_i = 1'b0; aw_lim = 0; w_lim = 0;
    repeat (2) @(negedge clk_i);
    #1;
    n_vec++; if (m_awvalid !== 1'b0) begin n_bad++; $display("FAIL reset_awvalid got=%0b exp=0", m_awvalid); end
    n_vec++; if (m_wvalid !== 1'b0) begin n_bad++; $display("FAIL reset_wvalid got=%0b exp=0", m_wvalid); end
    n_vec++; if (m_bready !== 1'b1) begin n_bad++; $display("FAIL reset_bready got=%0b exp=1", m_bready); end
    n_vec++; if (drain_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0b exp=0", drain_done_o); end
    n_vec++; if (outstd_cnt_o !== 4'd0) begin n_bad++; $display("FAIL reset_outstd got=%0d exp=0", outstd_cnt_o); end
    n_vec++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%0b exp=0", err_o); end
    @(negedge clk_i); rst_ni = 1'b1; #1;
    n_vec++; if (req_awready !== 1'b1) begin n_bad++; $display("FAIL reset_awready got=%0b exp=1", req_awready); end
  endtask

  task automatic test_single_write();
    @(negedge clk_i);
    req_awvalid = 1'b1; req_addr = 64'h1000; req_wvalid = 1'b1; req_data = {32{16'h1234}}; req_strb = '1;
    #1;
    n_vec++; if ({req_awready, req_wready} !== 2'b11) begin n_bad++; $display("FAIL sw_accept got=%b exp=11", {req_awready, req_wready}); end
    @(negedge clk_i); req_awvalid = 1'b0; req_wvalid = 1'b0; #1;
    n_vec++; if (m_awvalid !== 1'b1) begin n_bad++; $display("FAIL sw_awvalid got=%0b exp=1", m_awvalid); end
    n_vec++; if (m_awaddr !== 64'h1000) begin n_bad++; $display("FAIL sw_awaddr got=%h exp=1000", m_awaddr); end
    n_vec++; if ({m_awid, m_awlen, m_awsize, m_awburst} !== {4'd0, 8'd0, 3'd6, 2'b01}) begin
      n_bad++; $display("FAIL sw_awconst got=%h/%h/%h/%h exp=0/0/6/1", m_awid, m_awlen, m_awsize, m_awburst); end
    @(negedge clk_i); #1;
    n_vec++; if ({m_awvalid, m_wvalid} !== 2'b01) begin n_bad++; $display("FAIL sw_wvalid got=%b exp=01", {m_awvalid, m_wvalid}); end
    n_vec++; if (m_wdata !== {32{16'h1234}}) begin n_bad++; $display("FAIL sw_wdata got=%h", m_wdata); end
    n_vec++; if ({m_wstrb, m_wlast} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b1}) begin n_bad++; $display("FAIL sw_wstrb_last got=%h/%0b", m_wstrb, m_wlast); end
    n_vec++; if (outstd_cnt_o !== 4'd1) begin n_bad++; $display("FAIL sw_outstd1 got=%0d exp=1", outstd_cnt_o); end
    @(negedge clk_i); m_bvalid = 1'b1; m_bresp = 2'b00; #1;
    n_vec++; if (m_wvalid !== 1'b0) begin n_bad++; $display("FAIL sw_wdone got=%0b exp=0", m_wvalid); end
    @(negedge clk_i); m_bvalid = 1'b0; #1;
    n_vec++; if (outstd_cnt_o !== 4'd0) begin n_bad++; $display("FAIL sw_outstd0 got=%0d exp=0", outstd_cnt_o); end
  endtask

  task automatic test_w_first();
    @(negedge clk_i); req_wvalid = 1'b1; req_data = pat(7);
    @(negedge clk_i); req_wvalid = 1'b0; #1;
    n_vec++; if ({m_wvalid, req_wready} !== 2'b00) begin n_bad++; $display("FAIL wf_hold1 got=%b exp=00", {m_wvalid, req_wready}); end
    @(negedge clk_i); #1;
    n_vec++; if (m_wvalid !== 1'b0) begin n_bad++; $display("FAIL wf_hold2 got=%0b exp=0", m_wvalid); end
    @(negedge clk_i); req_awvalid = 1'b1; req_addr = 64'h1040; #1;
    n_vec++; if (m_wvalid !== 1'b0) begin n_bad++; $display("FAIL wf_hold3 got=%0b exp=0", m_wvalid); end
    @(negedge clk_i); req_awvalid = 1'b0; #1;
    n_vec++; if ({m_awvalid, m_wvalid} !== 2'b10) begin n_bad++; $display("FAIL wf_aw_first got=%b exp=10", {m_awvalid, m_wvalid}); end
    @(negedge clk_i); #1;
    n_vec++; if ({m_awvalid, m_wvalid} !== 2'b01) begin n_bad++; $display("FAIL wf_w_after got=%b exp=01", {m_awvalid, m_wvalid}); end
    n_vec++; if (m_wdata !== pat(7)) begin n_bad++; $display("FAIL wf_wdata got=%h", m_wdata); end
    @(negedge clk_i); m_bvalid = 1'b1; #1;
    @(negedge clk_i); m_bvalid = 1'b0; #1;
    n_vec++; if ({m_wvalid, outstd_cnt_o} !== {1'b0, 4'd0}) begin n_bad++; $display("FAIL wf_retire got=%0b/%0d exp=0/0", m_wvalid, outstd_cnt_o); end
  endtask

  task automatic test_outstanding_cap();
    int n;
    clear_traffic(64'h4000); aw_lim = 10; w_lim = 10;
    repeat (30) run_cycle();
    n_vec++; if (aw_hs != 8) begin n_bad++; $display("FAIL cap_aw_hs got=%0d exp=8", aw_hs); end
    n_vec++; if (outstd_cnt_o !== 4'd8) begin n_bad++; $display("FAIL cap_outstd got=%0d exp=8", outstd_cnt_o); end
    n_vec++; if ({req_awready, m_awvalid} !== 2'b00) begin n_bad++; $display("FAIL cap_blocked got=%b exp=00", {req_awready, m_awvalid}); end
    n_vec++; if (w_hs != 8) begin n_bad++; $display("FAIL cap_w_hs got=%0d exp=8", w_hs); end
    b_force = 1'b1; run_cycle(); b_force = 1'b0; run_cycle();
    n_vec++; if (aw_hs != 9) begin n_bad++; $display("FAIL cap_release got=%0d exp=9", aw_hs); end
    n_vec++; if (!got_aw || cap_awaddr !== 64'h4200) begin n_bad++; $display("FAIL cap_9th_addr got=%0b/%h exp=1/4200", got_aw, cap_awaddr); end
    b_auto = 1'b1; n = 0;
    while (!(b_hs == 10 && w_hs == 10) && n < 60) begin run_cycle(); n++; end
    run_cycle();
    n_vec++; if ({aw_hs, w_hs, b_hs} !== {32'd10, 32'd10, 32'd10}) begin n_bad++; $display("FAIL cap_totals got=%0d/%0d/%0d exp=10/10/10", aw_hs, w_hs, b_hs); end
    n_vec++; if (outstd_cnt_o !== 4'd0) begin n_bad++; $display("FAIL cap_outstd0 got=%0d exp=0", outstd_cnt_o); end
  endtask

  task automatic test_backpressure();
    @(negedge clk_i); m_awready = 1'b0; req_awvalid = 1'b1; req_addr = 64'h3000; req_wvalid = 1'b1; req_data = pat(3);
    @(negedge clk_i); req_awvalid = 1'b0; req_wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      n_vec++; if ({m_awvalid, m_awaddr, m_wvalid} !== {1'b1, 64'h3000, 1'b0}) begin
        n_bad++; $display("FAIL bp_hold%0d got=%0b/%h/%0b exp=1/3000/0", i, m_awvalid, m_awaddr, m_wvalid); end
    end
    @(negedge clk_i); m_awready = 1'b1; #1;
    @(negedge clk_i); m_bvalid = 1'b1; #1;
    n_vec++; if ({m_wvalid, m_wdata} !== {1'b1, pat(3)}) begin n_bad++; $display("FAIL bp_w got=%0b/%h", m_wvalid, m_wdata); end
    @(negedge clk_i); m_bvalid = 1'b0; #1;
    n_vec++; if ({m_awvalid, m_wvalid, outstd_cnt_o} !== {2'b00, 4'd0}) begin n_bad++; $display("FAIL bp_idle got=%0b/%0b/%0d", m_awvalid, m_wvalid, outstd_cnt_o); end
  endtask

  task automatic test_back_to_back();
    int n, acc_cyc;
    clear_traffic(64'h2000); aw_lim = 64; w_lim = 64; b_auto = 1'b1; n = 0; acc_cyc = 0;
    while (!(b_hs == 64 && w_hs == 64) && n < 300) begin
      run_cycle(); n++;
      if (aw_sent == 64 && acc_cyc == 0) acc_cyc = n;
      if (got_aw) begin
        n_vec++; if (cap_awaddr !== 64'h2000 + 64'(64 * (aw_hs - 1))) begin n_bad++; $display("FAIL b2b_addr%0d got=%h", aw_hs - 1, cap_awaddr); end
      end
      if (got_w) begin
        n_vec++; if (cap_wdata !== pat(w_hs - 1)) begin n_bad++; $display("FAIL b2b_data%0d got=%h", w_hs - 1, cap_wdata[31:0]); end
      end
    end
    run_cycle();
    n_vec++; if ({aw_hs, w_hs, b_hs} !== {32'd64, 32'd64, 32'd64}) begin n_bad++; $display("FAIL b2b_totals got=%0d/%0d/%0d exp=64", aw_hs, w_hs, b_hs); end
    n_vec++; if (acc_cyc != 64) begin n_bad++; $display("FAIL b2b_rate got=%0d exp=64", acc_cyc); end
    n_vec++; if (outstd_cnt_o !== 4'd0) begin n_bad++; $display("FAIL b2b_outstd0 got=%0d exp=0", outstd_cnt_o); end
  endtask

  task automatic test_drain();
    int n;
    clear_traffic(64'h5000); aw_lim = 3; w_lim = 3; n = 0;
    while (w_hs < 3 && n < 20) begin run_cycle(); n++; end
    n_vec++; if (outstd_cnt_o !== 4'd3) begin n_bad++; $display("FAIL dr_inflight got=%0d exp=3", outstd_cnt_o); end
    @(negedge clk_i); req_awvalid = 1'b0; req_wvalid = 1'b0; drain_req_i = 1'b1;
    @(negedge clk_i); drain_req_i = 1'b0; req_awvalid = 1'b1; req_addr = 64'h6000; req_wvalid = 1'b1; m_bvalid = 1'b1; #1;
    n_vec++; if ({req_awready, req_wready, drain_done_o} !== 3'b000) begin n_bad++; $display("FAIL dr_noaccept got=%b exp=000", {req_awready, req_wready, drain_done_o}); end
    @(negedge clk_i); #1;
    n_vec++; if (drain_done_o !== 1'b0) begin n_bad++; $display("FAIL dr_early2 got=%0b exp=0", drain_done_o); end
    @(negedge clk_i); #1;
    n_vec++; if ({drain_done_o, outstd_cnt_o} !== {1'b0, 4'd1}) begin n_bad++; $display("FAIL dr_early3 got=%0b/%0d exp=0/1", drain_done_o, outstd_cnt_o); end
    @(negedge clk_i); m_bvalid = 1'b0; req_awvalid = 1'b0; req_wvalid = 1'b0; #1;
    n_vec++; if (drain_done_o !== 1'b1) begin n_bad++; $display("FAIL dr_pulse got=%0b exp=1", drain_done_o); end
    @(negedge clk_i); #1;
    n_vec++; if ({drain_done_o, outstd_cnt_o} !== {1'b0, 4'd0}) begin n_bad++; $display("FAIL dr_pulse_end got=%0b/%0d exp=0/0", drain_done_o, outstd_cnt_o); end
    // drain while already idle
    @(negedge clk_i); drain_req_i = 1'b1; #1;
    n_vec++; if (drain_done_o !== 1'b0) begin n_bad++; $display("FAIL dr_idle0 got=%0b exp=0", drain_done_o); end
    @(negedge clk_i); drain_req_i = 1'b0; #1;
    n_vec++; if (drain_done_o !== 1'b0) begin n_bad++; $display("FAIL dr_idle1 got=%0b exp=0", drain_done_o); end
    @(negedge clk_i); #1;
    n_vec++; if (drain_done_o !== 1'b1) begin n_bad++; $display("FAIL dr_idle2 got=%0b exp=1", drain_done_o); end
    @(negedge clk_i); #1;
    n_vec++; if (drain_done_o !== 1'b0) begin n_bad++; $display("FAIL dr_idle3 got=%0b exp=0", drain_done_o); end
  endtask

  task automatic test_err();
    @(negedge clk_i); m_bvalid = 1'b1; m_bresp = 2'b10;
    @(negedge clk_i); m_bvalid = 1'b0; m_bresp = 2'b00; #1;
    n_vec++; if (err_o !== ERR_EXP) begin n_bad++; $display("FAIL err_set got=%0b exp=%0b", err_o, ERR_EXP); end
    n_vec++; if (outstd_cnt_o !== 4'd0) begin n_bad++; $display("FAIL err_cnt_floor got=%0d exp=0", outstd_cnt_o); end
    @(negedge clk_i); #1;
    n_vec++; if (err_o !== ERR_EXP) begin n_bad++; $display("FAIL err_sticky got=%0b exp=%0b", err_o, ERR_EXP); end
    @(negedge clk_i); err_clr_i = 1'b1;
    @(negedge clk_i); err_clr_i = 1'b0; #1;
    n_vec++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_clr got=%0b exp=0", err_o); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i); m_awready = 1'b0; req_awvalid = 1'b1; req_addr = 64'h7000;
    @(negedge clk_i); req_awvalid = 1'b0; #1;
    n_vec++; if (m_awvalid !== 1'b1) begin n_bad++; $display("FAIL rm_loaded got=%0b exp=1", m_awvalid); end
    rst_ni = 1'b0; #1;
    n_vec++; if ({m_awvalid, outstd_cnt_o} !== {1'b0, 4'd0}) begin n_bad++; $display("FAIL rm_cleared got=%0b/%0d exp=0/0", m_awvalid, outstd_cnt_o); end
    @(negedge clk_i); rst_ni = 1'b1; m_awready = 1'b1;
    @(negedge clk_i); #1;
    n_vec++; if (m_awvalid !== 1'b0) begin n_bad++; $display("FAIL rm_after got=%0b exp=0", m_awvalid); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_w_first();
    test_outstanding_cap();
    test_backpressure();
    test_back_to_back();
    test_drain();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
